// File: rtl/mc_ctrl_if.sv
// mc_ctrl_if: control bundle between the multi-cycle MIPS control unit and its datapath
interface mc_ctrl_if #(
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 32
);
  logic [5:0]         Op;
  logic [5:0]         Func;
  logic               Zero;
  logic               mem_ready;
  logic               PCWr;
  logic               IRWr;
  logic [1:0]         PCSrc;
  logic               MemRead;
  logic               MemWrite;
  logic               IorD;
  logic [1:0]         MemtoReg;
  logic [ALUOP_W-1:0] ALUOp;
  logic               ALUSrcA;
  logic [1:0]         ALUSrcB;
  logic               RegWrite;
  logic [1:0]         RegDst;
  logic               illegal;
  logic [CNT_W-1:0]   instr_cnt;
  logic [2:0]         state;
  modport master (
    input  Op, Func, Zero, mem_ready,
    output PCWr, IRWr, PCSrc, MemRead, MemWrite, IorD, MemtoReg, ALUOp,
           ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal, instr_cnt, state
  );
  modport slave (
    output Op, Func, Zero, mem_ready,
    input  PCWr, IRWr, PCSrc, MemRead, MemWrite, IorD, MemtoReg, ALUOp,
           ALUSrcA, ALUSrcB, RegWrite, RegDst, illegal, instr_cnt, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control FSM with memory ready handshake and retired-instruction counter
module mc_ctrl #(
  parameter int ALUOP_W = 4,
  parameter int MEM_HS  = 1,
  parameter int CNT_W   = 32
) (
  input logic        clk,
  input logic        rst_n,
  mc_ctrl_if.master  bus
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4} state_t;
  state_t             st, nxt;
  logic [CNT_W-1:0]   cnt;
  logic               rdy, retire;
  logic               pcwr, irwr, memread, memwrite, iord, alusrca, regwrite, illegal;
  logic [1:0]         pcsrc, memtoreg, alusrcb, regdst;
  logic [ALUOP_W-1:0] aluop;
  logic               rtype, i_addu, i_subu, i_jr, i_ori, i_lui, i_lw, i_sw, i_beq, i_j, i_jal, legal;
  assign rdy    = bus.mem_ready | (MEM_HS == 0);
  assign rtype  = bus.Op == 6'h00;
  assign i_addu = rtype && bus.Func == 6'h21;
  assign i_subu = rtype && bus.Func == 6'h23;
  assign i_jr   = rtype && bus.Func == 6'h08;
  assign i_ori  = bus.Op == 6'h0d;
  assign i_lui  = bus.Op == 6'h0f;
  assign i_lw   = bus.Op == 6'h23;
  assign i_sw   = bus.Op == 6'h2b;
  assign i_beq  = bus.Op == 6'h04;
  assign i_j    = bus.Op == 6'h02;
  assign i_jal  = bus.Op == 6'h03;
  assign legal  = i_addu | i_subu | i_jr | i_ori | i_lui | i_lw | i_sw | i_beq | i_j | i_jal;
  // Per-state control decode, next-state selection and retirement detection
  always_comb begin
    pcwr     = 1'b0;
    irwr     = 1'b0;
    pcsrc    = 2'd0;
    memread  = 1'b0;
    memwrite = 1'b0;
    iord     = 1'b0;
    memtoreg = 2'd0;
    aluop    = '0;
    alusrca  = 1'b0;
    alusrcb  = 2'd0;
    regwrite = 1'b0;
    regdst   = 2'd0;
    illegal  = 1'b0;
    retire   = 1'b0;
    nxt      = FETCH;
    case (st)
      FETCH: begin
        memread = 1'b1;
        alusrcb = 2'd3;
        aluop   = ALUOP_W'(2);
        pcwr    = rdy;
        irwr    = rdy;
        nxt     = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        illegal = ~legal;
        pcwr    = i_j;
        pcsrc   = i_j ? 2'd2 : 2'd0;
        retire  = i_j;
        nxt     = (legal && !i_j) ? EXEC : FETCH;
      end
      EXEC: begin
        alusrca  = ~(i_jal | i_jr);
        alusrcb  = (i_ori | i_lui) ? 2'd1 : (i_lw | i_sw) ? 2'd2 : 2'd0;
        aluop    = i_ori ? ALUOP_W'(1) : i_lui ? ALUOP_W'(4) : (i_subu | i_beq) ? ALUOP_W'(3) :
                   (i_addu | i_lw | i_sw) ? ALUOP_W'(2) : ALUOP_W'(0);
        pcsrc    = i_beq ? 2'd1 : i_jal ? 2'd2 : i_jr ? 2'd3 : 2'd0;
        pcwr     = i_beq ? bus.Zero : (i_jal | i_jr);
        regwrite = i_jal;
        regdst   = i_jal ? 2'd2 : 2'd0;
        memtoreg = i_jal ? 2'd2 : 2'd0;
        retire   = i_beq | i_jal | i_jr;
        nxt      = (i_lw | i_sw) ? MEM : (i_beq | i_jal | i_jr) ? FETCH : WB;
      end
      MEM: begin
        iord     = 1'b1;
        memread  = i_lw;
        memwrite = i_sw & rdy;
        retire   = i_sw & rdy;
        nxt      = !rdy ? MEM : i_lw ? WB : FETCH;
      end
      WB: begin
        regwrite = 1'b1;
        regdst   = (i_addu | i_subu) ? 2'd1 : 2'd0;
        memtoreg = i_lw ? 2'd1 : 2'd0;
        retire   = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end
  // State register and retired-instruction counter; reset abandons any instruction in flight
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st  <= FETCH;
      cnt <= '0;
    end else begin
      st  <= nxt;
      if (retire) cnt <= cnt + CNT_W'(1);
    end
  assign bus.PCWr      = pcwr & rst_n;
  assign bus.IRWr      = irwr & rst_n;
  assign bus.MemWrite  = memwrite & rst_n;
  assign bus.RegWrite  = regwrite & rst_n;
  assign bus.PCSrc     = pcsrc;
  assign bus.MemRead   = memread;
  assign bus.IorD      = iord;
  assign bus.MemtoReg  = memtoreg;
  assign bus.ALUOp     = aluop;
  assign bus.ALUSrcA   = alusrca;
  assign bus.ALUSrcB   = alusrcb;
  assign bus.RegDst    = regdst;
  assign bus.illegal   = illegal;
  assign bus.instr_cnt = cnt;
  assign bus.state     = st;
endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed checks of the multi-cycle control FSM sequencing, handshake waits and counter
module tb_mc_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int irwr_pulses = 0;
  int c0;
  mc_ctrl_if #(.ALUOP_W(4), .CNT_W(4)) b();
  mc_ctrl #(.ALUOP_W(4), .MEM_HS(1), .CNT_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  always #5 clk = ~clk;
  // Cycle counter for latency checks
  always @(posedge clk) cyc++;
  // Count cycles in which IRWr is asserted, sampled mid-cycle
  always @(negedge clk) if (b.IRWr === 1'b1) irwr_pulses++;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    b.Op = 6'h00; b.Func = 6'h21; b.Zero = 1'b0; b.mem_ready = 1'b1;
    repeat (2) tick;
    chk("rst_state", 32'(b.state), 0);
    chk("rst_cnt", 32'(b.instr_cnt), 0);
    chk("rst_pcwr", 32'(b.PCWr), 0);
    chk("rst_irwr", 32'(b.IRWr), 0);
    chk("rst_memread", 32'(b.MemRead), 1);
    chk("rst_alusrcb", 32'(b.ALUSrcB), 3);
    chk("rst_aluop", 32'(b.ALUOp), 2);
    rst_n = 1'b1;
    #1;
    chk("addu_f_pcwr", 32'(b.PCWr), 1);
    chk("addu_f_irwr", 32'(b.IRWr), 1);
    chk("addu_f_regwrite", 32'(b.RegWrite), 0);
    tick;
    chk("addu_d_state", 32'(b.state), 1);
    chk("addu_d_illegal", 32'(b.illegal), 0);
    chk("addu_d_regwrite", 32'(b.RegWrite), 0);
    tick;
    chk("addu_e_state", 32'(b.state), 2);
    chk("addu_e_alusrca", 32'(b.ALUSrcA), 1);
    chk("addu_e_alusrcb", 32'(b.ALUSrcB), 0);
    chk("addu_e_aluop", 32'(b.ALUOp), 2);
    chk("addu_e_regwrite", 32'(b.RegWrite), 0);
    tick;
    chk("addu_w_state", 32'(b.state), 4);
    chk("addu_w_regwrite", 32'(b.RegWrite), 1);
    chk("addu_w_regdst", 32'(b.RegDst), 1);
    chk("addu_w_memtoreg", 32'(b.MemtoReg), 0);
    tick;
    chk("addu_done_state", 32'(b.state), 0);
    chk("addu_cnt", 32'(b.instr_cnt), 1);
    chk("addu_f2_regwrite", 32'(b.RegWrite), 0);
    b.Op = 6'h23; b.mem_ready = 1'b0;
    c0 = cyc; irwr_pulses = 0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_fwait_state", 32'(b.state), 0);
      chk("lw_fwait_irwr", 32'(b.IRWr), 0);
      chk("lw_fwait_pcwr", 32'(b.PCWr), 0);
      chk("lw_fwait_memread", 32'(b.MemRead), 1);
      tick;
    end
    b.mem_ready = 1'b1;
    #1;
    chk("lw_f_irwr", 32'(b.IRWr), 1);
    tick;
    chk("lw_d_state", 32'(b.state), 1);
    tick;
    chk("lw_e_state", 32'(b.state), 2);
    chk("lw_e_alusrcb", 32'(b.ALUSrcB), 2);
    chk("lw_e_aluop", 32'(b.ALUOp), 2);
    b.mem_ready = 1'b0;
    tick;
    for (int i = 0; i < 2; i++) begin
      chk("lw_mwait_state", 32'(b.state), 3);
      chk("lw_mwait_memread", 32'(b.MemRead), 1);
      chk("lw_mwait_iord", 32'(b.IorD), 1);
      chk("lw_mwait_memwrite", 32'(b.MemWrite), 0);
      tick;
    end
    b.mem_ready = 1'b1;
    #1;
    chk("lw_m_memread", 32'(b.MemRead), 1);
    tick;
    chk("lw_w_state", 32'(b.state), 4);
    chk("lw_w_regwrite", 32'(b.RegWrite), 1);
    chk("lw_w_memtoreg", 32'(b.MemtoReg), 1);
    chk("lw_w_regdst", 32'(b.RegDst), 0);
    tick;
    chk("lw_done_state", 32'(b.state), 0);
    chk("lw_cycles", 32'(cyc - c0), 10);
    chk("lw_irwr_pulses", 32'(irwr_pulses), 1);
    chk("lw_cnt", 32'(b.instr_cnt), 2);
    b.Op = 6'h04; b.Zero = 1'b1; c0 = cyc;
    tick;
    tick;
    chk("beq1_e_state", 32'(b.state), 2);
    chk("beq1_e_pcwr", 32'(b.PCWr), 1);
    chk("beq1_e_pcsrc", 32'(b.PCSrc), 1);
    chk("beq1_e_aluop", 32'(b.ALUOp), 3);
    tick;
    chk("beq1_done_state", 32'(b.state), 0);
    chk("beq1_cycles", 32'(cyc - c0), 3);
    chk("beq1_cnt", 32'(b.instr_cnt), 3);
    b.Zero = 1'b0; c0 = cyc;
    tick;
    tick;
    chk("beq0_e_pcwr", 32'(b.PCWr), 0);
    chk("beq0_e_pcsrc", 32'(b.PCSrc), 1);
    tick;
    chk("beq0_done_state", 32'(b.state), 0);
    chk("beq0_cycles", 32'(cyc - c0), 3);
    chk("beq0_cnt", 32'(b.instr_cnt), 4);
    b.Op = 6'h03;
    tick;
    tick;
    chk("jal_e_regwrite", 32'(b.RegWrite), 1);
    chk("jal_e_regdst", 32'(b.RegDst), 2);
    chk("jal_e_memtoreg", 32'(b.MemtoReg), 2);
    chk("jal_e_pcwr", 32'(b.PCWr), 1);
    chk("jal_e_pcsrc", 32'(b.PCSrc), 2);
    tick;
    chk("jal_cnt", 32'(b.instr_cnt), 5);
    b.Op = 6'h00; b.Func = 6'h08;
    tick;
    tick;
    chk("jr_e_pcwr", 32'(b.PCWr), 1);
    chk("jr_e_pcsrc", 32'(b.PCSrc), 3);
    chk("jr_e_regwrite", 32'(b.RegWrite), 0);
    tick;
    chk("jr_cnt", 32'(b.instr_cnt), 6);
    b.Op = 6'h02; c0 = cyc;
    tick;
    chk("j_d_state", 32'(b.state), 1);
    chk("j_d_pcwr", 32'(b.PCWr), 1);
    chk("j_d_pcsrc", 32'(b.PCSrc), 2);
    tick;
    chk("j_done_state", 32'(b.state), 0);
    chk("j_cycles", 32'(cyc - c0), 2);
    chk("j_cnt", 32'(b.instr_cnt), 7);
    b.Op = 6'h3f;
    tick;
    chk("ill_d_illegal", 32'(b.illegal), 1);
    chk("ill_d_pcwr", 32'(b.PCWr), 0);
    chk("ill_d_regwrite", 32'(b.RegWrite), 0);
    chk("ill_d_memwrite", 32'(b.MemWrite), 0);
    tick;
    chk("ill_done_state", 32'(b.state), 0);
    chk("ill_done_illegal", 32'(b.illegal), 0);
    chk("ill_cnt", 32'(b.instr_cnt), 7);
    b.Op = 6'h2b;
    tick;
    tick;
    chk("sw_e_alusrcb", 32'(b.ALUSrcB), 2);
    tick;
    chk("sw_m_state", 32'(b.state), 3);
    chk("sw_m_memwrite", 32'(b.MemWrite), 1);
    chk("sw_m_memread", 32'(b.MemRead), 0);
    chk("sw_m_iord", 32'(b.IorD), 1);
    rst_n = 1'b0;
    #1;
    chk("sw_rst_memwrite", 32'(b.MemWrite), 0);
    chk("sw_rst_state", 32'(b.state), 0);
    chk("sw_rst_cnt", 32'(b.instr_cnt), 0);
    tick;
    rst_n = 1'b1;
    b.Op = 6'h00; b.Func = 6'h21;
    #1;
    chk("rel_state", 32'(b.state), 0);
    chk("rel_cnt", 32'(b.instr_cnt), 0);
    for (int i = 0; i < 15; i++) repeat (4) tick;
    chk("wrap_cnt15", 32'(b.instr_cnt), 15);
    repeat (4) tick;
    chk("wrap_state", 32'(b.state), 0);
    chk("wrap_cnt0", 32'(b.instr_cnt), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
